tmc_spi_scheduler: RTL and testbench

// Owns the shared SPI master to the four TMC5130 drivers and sequences every 40-bit datagram on it.

---
 rtl/tmc_spi_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_tmc_spi_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmc_spi_scheduler.sv
// Sequencer for the shared TMC5130 SPI master: arbitrates host register
// requests against a periodic DRV_STATUS poll and hides the two-datagram read.
module tmc_spi_scheduler #(
  parameter int unsigned POLL_DIV  = 50000,
  parameter logic [6:0]  POLL_ADDR = 7'h6F,
  parameter int unsigned CS_GAP    = 8,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        host_req_i,
  input  logic [1:0]  host_drv_i,
  input  logic        host_wr_i,
  input  logic [6:0]  host_addr_i,
  input  logic [31:0] host_wdata_i,
  output logic        host_ack_o,
  output logic        host_done_o,
  output logic [31:0] host_rdata_o,
  output logic [7:0]  host_status_o,
  input  logic        poll_en_i,
  input  logic [1:0]  stat_sel_i,
  output logic [31:0] stat_data_o,
  output logic [3:0]  stat_valid_o,
  output logic        spi_start_o,
  output logic [1:0]  spi_cs_o,
  output logic [39:0] spi_tx_o,
  input  logic        spi_done_i,
  input  logic [39:0] spi_rx_i,
  output logic        busy_o
);

  localparam int PW = $clog2(POLL_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(CS_GAP + 2);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_CYC   = GW'(CS_GAP);
  localparam logic [39:0]   RX_TMO    = 40'hFF_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_ISSUE1, S_WAIT1, S_GAP2, S_ISSUE2, S_WAIT2, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     gap_cnt_q;
  logic [TW-1:0]     tmo_cnt_q;
  logic [PW-1:0]     poll_cnt_q;
  logic              poll_pend_q;
  logic [1:0]        poll_drv_q;
  logic              last_host_q;
  logic              cur_host_q;
  logic              cur_wr_q;
  logic [1:0]        cur_drv_q;
  logic [1:0]        spi_cs_q;
  logic [39:0]       spi_tx_q;
  logic [31:0]       host_rdata_q;
  logic [7:0]        host_status_q;
  logic [3:0][31:0]  stat_q;
  logic [3:0]        stat_valid_q;

  logic        grant_host, grant_poll, fin, abort;
  logic        wait_st, gap_ok, done_in_wait, tmo_hit;
  logic [39:0] rx_sel;

  assign wait_st      = (state_q == S_WAIT1) || (state_q == S_WAIT2);
  assign gap_ok       = gap_cnt_q >= GAP_CYC;
  assign done_in_wait = wait_st && spi_done_i;
  assign tmo_hit      = wait_st && !spi_done_i && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    grant_host = 1'b0;
    grant_poll = 1'b0;
    fin        = 1'b0;
    abort      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On contention the side that did not win last time gets the slot.
        if (host_req_i && (!poll_pend_q || !last_host_q)) begin
          grant_host = 1'b1;
          state_d    = S_GAP;
        end else if (poll_pend_q) begin
          grant_poll = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_GAP:    if (gap_ok) state_d = S_ISSUE1;
      S_ISSUE1: state_d = S_WAIT1;
      S_WAIT1: begin
        if (spi_done_i) begin
          if (cur_wr_q) begin
            state_d = S_DONE;
            fin     = 1'b1;
          end else begin
            state_d = S_GAP2;
          end
        end else if (tmo_hit) begin
          state_d = S_DONE;
          fin     = 1'b1;
          abort   = 1'b1;
        end
      end
      S_GAP2:   if (gap_ok) state_d = S_ISSUE2;
      S_ISSUE2: state_d = S_WAIT2;
      S_WAIT2: begin
        if (spi_done_i) begin
          state_d = S_DONE;
          fin     = 1'b1;
        end else if (tmo_hit) begin
          state_d = S_DONE;
          fin     = 1'b1;
          abort   = 1'b1;
        end
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign rx_sel = abort ? RX_TMO : spi_rx_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      gap_cnt_q     <= GAP_CYC;
      tmo_cnt_q     <= '0;
      poll_cnt_q    <= '0;
      poll_pend_q   <= 1'b0;
      poll_drv_q    <= 2'd0;
      last_host_q   <= 1'b0;
      cur_host_q    <= 1'b0;
      cur_wr_q      <= 1'b0;
      cur_drv_q     <= 2'd0;
      spi_cs_q      <= 2'd0;
      spi_tx_q      <= '0;
      host_rdata_q  <= '0;
      host_status_q <= '0;
      stat_q        <= '0;
      stat_valid_q  <= '0;
    end else begin
      // Gap counter saturates at CS_GAP so an idle bus never delays a grant.
      if (done_in_wait || tmo_hit) gap_cnt_q <= '0;
      else if (!gap_ok)            gap_cnt_q <= gap_cnt_q + 1'b1;

      if (spi_start_o)  tmo_cnt_q <= '0;
      else if (wait_st) tmo_cnt_q <= tmo_cnt_q + 1'b1;

      if (grant_host) begin
        last_host_q <= 1'b1;
        cur_host_q  <= 1'b1;
        cur_wr_q    <= host_wr_i;
        cur_drv_q   <= host_drv_i;
        spi_cs_q    <= host_drv_i;
        spi_tx_q    <= {host_wr_i, host_addr_i, host_wr_i ? host_wdata_i : 32'h0};
      end else if (grant_poll) begin
        last_host_q <= 1'b0;
        cur_host_q  <= 1'b0;
        cur_wr_q    <= 1'b0;
        cur_drv_q   <= poll_drv_q;
        spi_cs_q    <= poll_drv_q;
        spi_tx_q    <= {1'b0, POLL_ADDR, 32'h0};
      end

      if (fin && cur_host_q) begin
        host_rdata_q  <= rx_sel[31:0];
        host_status_q <= rx_sel[39:32];
      end
      if (fin && !cur_host_q) begin
        if (abort) begin
          stat_valid_q[cur_drv_q] <= 1'b0;
        end else begin
          stat_q[cur_drv_q]       <= rx_sel[31:0];
          stat_valid_q[cur_drv_q] <= 1'b1;
        end
      end

      if (!poll_en_i) begin
        poll_cnt_q  <= '0;
        poll_pend_q <= 1'b0;
        poll_drv_q  <= 2'd0;
      end else begin
        if (poll_cnt_q == POLL_LAST) begin
          poll_cnt_q  <= '0;
          poll_pend_q <= 1'b1;
        end else begin
          poll_cnt_q <= poll_cnt_q + 1'b1;
        end
        // Round completion wins over a coincident wrap: a round is never queued twice.
        if (fin && !cur_host_q) begin
          if (cur_drv_q == 2'd3) begin
            poll_pend_q <= 1'b0;
            poll_drv_q  <= 2'd0;
          end else begin
            poll_drv_q <= cur_drv_q + 2'd1;
          end
        end
      end
    end
  end

  assign host_ack_o    = grant_host;
  assign host_done_o   = (state_q == S_DONE) && cur_host_q;
  assign host_rdata_o  = host_rdata_q;
  assign host_status_o = host_status_q;
  assign stat_data_o   = stat_q[stat_sel_i];
  assign stat_valid_o  = stat_valid_q;
  assign spi_start_o   = (state_q == S_ISSUE1) || (state_q == S_ISSUE2);
  assign spi_cs_o      = spi_cs_q;
  assign spi_tx_o      = spi_tx_q;
  assign busy_o        = state_q != S_IDLE;

endmodule

// File: tb/tb_tmc_spi_scheduler.sv
// Directed bench for tmc_spi_scheduler: table of host transactions plus
// hand sequences for polling, arbitration, timeout and mid-transfer reset.
module tb_tmc_spi_scheduler;

  localparam int CS_GAP  = 8;
  localparam int TIMEOUT = 200;
  localparam logic [39:0] DEF_RX  = 40'h11_0000_5A5A;
  localparam logic [39:0] POLL_TX = 40'h6F_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_req, host_wr;
  logic [1:0]  host_drv;
  logic [6:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ack, host_done;
  logic [31:0] host_rdata;
  logic [7:0]  host_status;
  logic        poll_en;
  logic [1:0]  stat_sel;
  logic [31:0] stat_data;
  logic [3:0]  stat_valid;
  logic        spi_start, spi_done;
  logic [1:0]  spi_cs;
  logic [39:0] spi_tx, spi_rx;
  logic        busy;

  tmc_spi_scheduler #(.POLL_DIV(64), .POLL_ADDR(7'h6F), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(reset),
    .host_req_i(host_req), .host_drv_i(host_drv), .host_wr_i(host_wr),
    .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_ack_o(host_ack), .host_done_o(host_done),
    .host_rdata_o(host_rdata), .host_status_o(host_status),
    .poll_en_i(poll_en), .stat_sel_i(stat_sel),
    .stat_data_o(stat_data), .stat_valid_o(stat_valid),
    .spi_start_o(spi_start), .spi_cs_o(spi_cs), .spi_tx_o(spi_tx),
    .spi_done_i(spi_done), .spi_rx_i(spi_rx), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SPI master model: answers each spi_start after model_d cycles while budget lasts.
  logic [39:0] resp_q[$];
  logic [1:0]  cs_log[$];
  logic [39:0] tx_log[$];
  int          st_log[$];
  int          model_d = 3;
  int          model_budget = 1000000;
  logic [39:0] m_nxt;

  initial begin
    spi_done = 1'b0;
    spi_rx   = '0;
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        cs_log.push_back(spi_cs);
        tx_log.push_back(spi_tx);
        st_log.push_back(cyc);
        if (model_budget > 0) begin
          model_budget--;
          m_nxt = (resp_q.size() > 0) ? resp_q.pop_front() : DEF_RX;
          repeat (model_d) @(negedge clk);
          spi_rx   = m_nxt;
          spi_done = 1'b1;
          @(negedge clk);
          spi_done = 1'b0;
        end
      end
    end
  end

  // Called at a falling edge; returns at falling edge + 1 of the done cycle.
  task automatic host_txn(input string nm, input logic [1:0] drv, input logic wr,
                          input logic [6:0] addr, input logic [31:0] wdata,
                          output int ack_c, output int done_c,
                          output logic [31:0] rd, output logic [7:0] st);
    host_req = 1'b1; host_drv = drv; host_wr = wr; host_addr = addr; host_wdata = wdata;
    ack_c = -1; done_c = -1; rd = 'x; st = 'x;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (host_ack) begin ack_c = cyc; break; end
      @(negedge clk);
    end
    if (ack_c < 0) begin
      host_req = 1'b0;
      chk({nm, "_ack_seen"}, 64'd0, 64'd1);
      return;
    end
    @(negedge clk);
    host_req = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      #1;
      if (host_done) begin done_c = cyc; rd = host_rdata; st = host_status; break; end
      @(negedge clk);
    end
    if (done_c < 0) chk({nm, "_done_seen"}, 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [1:0]  drv;
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          d;
    logic [39:0] r1, r2;
    logic [39:0] etx;
    logic [31:0] erd;
    logic [7:0]  est;
    int          elat;
  } vec_t;

  vec_t vt[4];
  int   ack_c, done_c, base;
  logic [31:0] rd;
  logic [7:0]  st;
  int   ndone;

  initial begin
    vt[0] = '{2'd2, 1'b1, 7'h00, 32'h0000_0202, 40, 40'h03_1234_5678, 40'h0,
              40'h80_0000_0202, 32'h1234_5678, 8'h03, 43};
    vt[1] = '{2'd1, 1'b0, 7'h01, 32'h0, 10, 40'h05_0000_0000, 40'h05_0000_0001,
              40'h01_0000_0000, 32'h0000_0001, 8'h05, 33};
    vt[2] = '{2'd0, 1'b1, 7'h7F, 32'hFFFF_FFFF, 1, 40'h00_ABCD_EF01, 40'h0,
              40'hFF_FFFF_FFFF, 32'hABCD_EF01, 8'h00, 4};
    vt[3] = '{2'd3, 1'b0, 7'h6C, 32'hDEAD_BEEF, 3, 40'h7E_1111_1111, 40'h81_2222_3333,
              40'h6C_0000_0000, 32'h2222_3333, 8'h81, 19};

    reset = 1'b1; host_req = 1'b0; host_drv = 2'd0; host_wr = 1'b0;
    host_addr = '0; host_wdata = '0; poll_en = 1'b0; stat_sel = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and a quiet bus with polling off.
    repeat (100) @(negedge clk);
    chk("idle_starts", 64'(tx_log.size()), 64'd0);
    chk("rst_outs", {host_ack, host_done, host_rdata, host_status, stat_valid, spi_start, spi_cs, busy},
        64'd0);
    chk("rst_tx_stat", {spi_tx, 24'd0} | 64'(stat_data), 64'd0);

    for (int i = 0; i < 4; i++) begin
      resp_q.delete();
      resp_q.push_back(vt[i].r1);
      if (!vt[i].wr) resp_q.push_back(vt[i].r2);
      model_d = vt[i].d;
      base = tx_log.size();
      host_txn($sformatf("v%0d", i), vt[i].drv, vt[i].wr, vt[i].addr, vt[i].wdata,
               ack_c, done_c, rd, st);
      chk($sformatf("v%0d_lat", i), 64'(done_c - ack_c), 64'(vt[i].elat));
      chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vt[i].erd));
      chk($sformatf("v%0d_status", i), 64'(st), 64'(vt[i].est));
      chk($sformatf("v%0d_nstart", i), 64'(tx_log.size() - base), vt[i].wr ? 64'd1 : 64'd2);
      if (tx_log.size() > base) begin
        chk($sformatf("v%0d_cs", i), 64'(cs_log[base]), 64'(vt[i].drv));
        chk($sformatf("v%0d_tx", i), 64'(tx_log[base]), 64'(vt[i].etx));
      end
      if (!vt[i].wr && tx_log.size() > base + 1) begin
        chk($sformatf("v%0d_tx2", i), 64'(tx_log[base+1]), 64'(vt[i].etx));
        chk($sformatf("v%0d_space", i), 64'(st_log[base+1] - st_log[base]),
            64'(vt[i].d + CS_GAP + 2));
      end
      repeat (12) @(negedge clk);
    end

    // One poll round: drivers 0..3, two datagrams each.
    resp_q.delete();
    for (int d = 0; d < 4; d++) begin
      resp_q.push_back(40'h0);
      resp_q.push_back({8'h00, 32'hC0DE_0000 + 32'(d)});
    end
    model_d = 3;
    base = tx_log.size();
    poll_en = 1'b1;
    for (int i = 0; i < 3000 && tx_log.size() < base + 8; i++) @(negedge clk);
    for (int i = 0; i < 100 && stat_valid != 4'hF; i++) @(negedge clk);
    poll_en = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("poll_valid", 64'(stat_valid), 64'hF);
    if (tx_log.size() >= base + 8) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("poll_cs%0d", k), 64'(cs_log[base+k]), 64'(k / 2));
        chk($sformatf("poll_tx%0d", k), 64'(tx_log[base+k]), 64'(POLL_TX));
      end
    end else chk("poll_nstart", 64'(tx_log.size() - base), 64'd8);
    for (int d = 0; d < 4; d++) begin
      stat_sel = 2'(d);
      #1;
      chk($sformatf("poll_stat%0d", d), 64'(stat_data), 64'(32'hC0DE_0000 + 32'(d)));
    end
    repeat (12) @(negedge clk);

    // Host held high during a poll round: slots must alternate.
    resp_q.delete();
    base = tx_log.size();
    poll_en = 1'b1;
    for (int i = 0; i < 3000 && tx_log.size() == base; i++) @(negedge clk);
    ndone = 0;
    for (int h = 0; h < 3; h++) begin
      host_txn($sformatf("alt%0d", h), 2'd0, 1'b1, 7'h10, 32'h55, ack_c, done_c, rd, st);
      if (done_c >= 0) ndone++;
    end
    for (int i = 0; i < 500 && tx_log.size() < base + 11; i++) @(negedge clk);
    poll_en = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk("alt_ndone", 64'(ndone), 64'd3);
    if (tx_log.size() >= base + 11) begin
      for (int k = 0, e = 0; k < 4; k++) begin
        for (int j = 0; j < 2; j++, e++) begin
          chk($sformatf("alt_p%0d_cs", e), 64'(cs_log[base+e]), 64'(k));
          chk($sformatf("alt_p%0d_tx", e), 64'(tx_log[base+e]), 64'(POLL_TX));
        end
        if (k < 3) begin
          chk($sformatf("alt_h%0d_tx", e), 64'(tx_log[base+e]), 64'h90_0000_0055);
          e++;
        end
      end
    end else chk("alt_nstart", 64'(tx_log.size() - base), 64'd11);
    repeat (12) @(negedge clk);

    // Silent SPI master: read aborts after TIMEOUT.
    model_budget = 0;
    base = tx_log.size();
    host_txn("tmo", 2'd1, 1'b0, 7'h22, 32'h0, ack_c, done_c, rd, st);
    chk("tmo_lat", 64'(done_c - ack_c), 64'(TIMEOUT + 3));
    chk("tmo_status", 64'(st), 64'hFF);
    chk("tmo_rdata", 64'(rd), 64'd0);
    chk("tmo_nstart", 64'(tx_log.size() - base), 64'd1);
    repeat (12) @(negedge clk);

    // Reset while waiting on the second read datagram.
    model_budget = 1;
    model_d = 3;
    base = tx_log.size();
    host_req = 1'b1; host_drv = 2'd2; host_wr = 1'b0; host_addr = 7'h33;
    ack_c = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (host_ack) begin ack_c = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    host_req = 1'b0;
    for (int i = 0; i < 200 && tx_log.size() < base + 2; i++) @(negedge clk);
    chk("rstw_nstart", 64'(tx_log.size() - base), 64'd2);
    repeat (2) @(negedge clk);
    chk("rstw_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_valid", 64'(stat_valid), 64'd0);
    chk("rstw_status", 64'(host_status), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (host_done || spi_start || busy) ndone++;
    end
    chk("rstw_quiet", 64'(ndone), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
